// File: rtl/cmp_verdict_debouncer.sv
// ---------------------------------------------------------------------------
// cmp_verdict_debouncer
//
// Purpose:
//   Turns the per-sample gt/lt/eq flags of an 8-bit magnitude comparator into
//   a stable, debounced verdict. A new outcome is adopted only after RUN_LEN
//   consecutive valid samples agree on it. Cycles with in_valid=0 are ignored
//   and do not break a run. Illegal flag combinations are discarded, restart
//   the current run and set a sticky error flag.
//
// Optional feature (macro CMP_HIST_EN):
//   When defined, per-outcome saturating histogram counters are built.
//   When undefined, gt_cnt/lt_cnt/eq_cnt are tied to zero.
//
// Parameters:
//   RUN_LEN  consecutive agreeing samples needed to change the verdict (>=1)
//   CNT_W    width of the per-outcome counters
//
// Ports:
//   clk            in   1      rising-edge clock
//   rst            in   1      asynchronous active-high reset
//   clear          in   1      synchronous soft reset, same effect as rst
//   in_valid       in   1      gt_in/lt_in/eq_in carry a sample this cycle
//   gt_in          in   8      comparator A_gt_B vector
//   lt_in          in   8      comparator A_lt_B vector
//   eq_in          in   8      comparator A_equal_B vector
//   verdict        out  2      00 none, 01 LT, 10 GT, 11 EQ
//   verdict_valid  out  1      a verdict has been locked since reset/clear
//   verdict_chg    out  1      one-cycle pulse when the verdict changes
//   fsm_state      out  2      00 UNLOCKED, 01 QUALIFY, 10 LOCKED
//   err_sticky     out  1      an illegal flag combination has been seen
//   gt_cnt         out  CNT_W  legal GT samples, saturating
//   lt_cnt         out  CNT_W  legal LT samples, saturating
//   eq_cnt         out  CNT_W  legal EQ samples, saturating
// ---------------------------------------------------------------------------
module cmp_verdict_debouncer #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [7:0]       gt_in,
    input  logic [7:0]       lt_in,
    input  logic [7:0]       eq_in,
    output logic [1:0]       verdict,
    output logic             verdict_valid,
    output logic             verdict_chg,
    output logic [1:0]       fsm_state,
    output logic             err_sticky,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt
);

    localparam int RC_W = $clog2(RUN_LEN + 1);
    localparam logic [RC_W-1:0] RUN_ONE  = RC_W'(1);
    localparam logic [RC_W-1:0] RUN_DONE = RC_W'(RUN_LEN);

    typedef enum logic [1:0] {
        UNLOCKED = 2'b00,
        QUALIFY  = 2'b01,
        LOCKED   = 2'b10
    } state_t;

    localparam logic [1:0] O_NONE = 2'b00;
    localparam logic [1:0] O_LT   = 2'b01;
    localparam logic [1:0] O_GT   = 2'b10;
    localparam logic [1:0] O_EQ   = 2'b11;

    // Registered state
    state_t          state;
    logic [1:0]      candidate;
    logic [RC_W-1:0] run_cnt;

    // Next-state values
    state_t          state_nxt;
    logic [1:0]      candidate_nxt;
    logic [RC_W-1:0] run_cnt_nxt;
    logic [1:0]      verdict_nxt;
    logic            verdict_valid_nxt;
    logic            verdict_chg_nxt;
    logic            err_sticky_nxt;

    // Flag decode
    logic       upper_zero;
    logic [2:0] bit0s;
    logic       legal;
    logic [1:0] outcome;
    logic       take;       // a legal sample is consumed this cycle

    assign upper_zero = ~|{gt_in[7:1], lt_in[7:1], eq_in[7:1]};
    assign bit0s      = {gt_in[0], lt_in[0], eq_in[0]};
    assign legal      = upper_zero &&
                        (bit0s == 3'b100 || bit0s == 3'b010 || bit0s == 3'b001);
    assign outcome    = gt_in[0] ? O_GT : (lt_in[0] ? O_LT : O_EQ);
    assign take       = in_valid && legal && !clear;

    // Run length the candidate reaches if this sample extends or restarts it.
    logic [RC_W-1:0] run_tmp;

    // NOTE: every combinational output is given a default before any branch,
    // so no path leaves a signal unassigned and no latch can be inferred.
    always_comb begin
        state_nxt         = state;
        candidate_nxt     = candidate;
        run_cnt_nxt       = run_cnt;
        verdict_nxt       = verdict;
        verdict_valid_nxt = verdict_valid;
        verdict_chg_nxt   = 1'b0;
        err_sticky_nxt    = err_sticky;
        run_tmp           = '0;

        if (clear) begin
            state_nxt         = UNLOCKED;
            candidate_nxt     = O_NONE;
            run_cnt_nxt       = '0;
            verdict_nxt       = O_NONE;
            verdict_valid_nxt = 1'b0;
            err_sticky_nxt    = 1'b0;
        end else if (in_valid && !legal) begin
            // Illegal sample: discard it and restart any run in progress.
            err_sticky_nxt = 1'b1;
            run_cnt_nxt    = '0;
            candidate_nxt  = O_NONE;
            state_nxt      = verdict_valid ? LOCKED : UNLOCKED;
        end else if (in_valid) begin
            if (state == QUALIFY && outcome == verdict) begin
                // Challenger abandoned: the current verdict is confirmed again.
                state_nxt     = LOCKED;
                run_cnt_nxt   = '0;
                candidate_nxt = O_NONE;
            end else if (state != LOCKED || outcome != verdict) begin
                if (state != LOCKED && outcome == candidate)
                    run_tmp = run_cnt + RUN_ONE;
                else
                    run_tmp = RUN_ONE;

                if (run_tmp == RUN_DONE) begin
                    verdict_nxt       = outcome;
                    verdict_valid_nxt = 1'b1;
                    verdict_chg_nxt   = 1'b1;
                    state_nxt         = LOCKED;
                    run_cnt_nxt       = '0;
                    candidate_nxt     = O_NONE;
                end else begin
                    candidate_nxt = outcome;
                    run_cnt_nxt   = run_tmp;
                    // A differing sample while locked opens a challenge;
                    // before the first lock the FSM keeps collecting.
                    state_nxt     = (state == UNLOCKED) ? UNLOCKED : QUALIFY;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= UNLOCKED;
            candidate     <= O_NONE;
            run_cnt       <= '0;
            verdict       <= O_NONE;
            verdict_valid <= 1'b0;
            verdict_chg   <= 1'b0;
            err_sticky    <= 1'b0;
        end else begin
            state         <= state_nxt;
            candidate     <= candidate_nxt;
            run_cnt       <= run_cnt_nxt;
            verdict       <= verdict_nxt;
            verdict_valid <= verdict_valid_nxt;
            verdict_chg   <= verdict_chg_nxt;
            err_sticky    <= err_sticky_nxt;
        end
    end

    assign fsm_state = state;

`ifdef CMP_HIST_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gt_cnt <= '0;
            lt_cnt <= '0;
            eq_cnt <= '0;
        end else if (clear) begin
            gt_cnt <= '0;
            lt_cnt <= '0;
            eq_cnt <= '0;
        end else if (take) begin
            // Saturate at all-ones rather than wrapping.
            if (outcome == O_GT && gt_cnt != '1) gt_cnt <= gt_cnt + CNT_ONE;
            if (outcome == O_LT && lt_cnt != '1) lt_cnt <= lt_cnt + CNT_ONE;
            if (outcome == O_EQ && eq_cnt != '1) eq_cnt <= eq_cnt + CNT_ONE;
        end
    end
`else
    logic unused_take;
    assign unused_take = take;
    assign gt_cnt = '0;
    assign lt_cnt = '0;
    assign eq_cnt = '0;
`endif

endmodule

// File: tb/tb_cmp_verdict_debouncer.sv
// ---------------------------------------------------------------------------
// tb_cmp_verdict_debouncer
//
// Table-driven bench for cmp_verdict_debouncer (RUN_LEN=4, CNT_W=4), plus a
// second instance with RUN_LEN=1 sharing the same stimulus. Hand-written
// sequences cover immediate locking, asynchronous reset mid-run and the
// saturating histogram counters (expected values depend on CMP_HIST_EN).
// ---------------------------------------------------------------------------
module tb_cmp_verdict_debouncer;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             in_valid;
    logic [7:0]       gt_in, lt_in, eq_in;

    logic [1:0]       verdict, fsm_state;
    logic             verdict_valid, verdict_chg, err_sticky;
    logic [CNT_W-1:0] gt_cnt, lt_cnt, eq_cnt;

    logic [1:0]       verdict1, fsm_state1;
    logic             verdict_valid1, verdict_chg1, err_sticky1;
    logic [CNT_W-1:0] gt_cnt1, lt_cnt1, eq_cnt1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    cmp_verdict_debouncer #(.RUN_LEN(4), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .gt_in(gt_in), .lt_in(lt_in), .eq_in(eq_in),
        .verdict(verdict), .verdict_valid(verdict_valid),
        .verdict_chg(verdict_chg), .fsm_state(fsm_state),
        .err_sticky(err_sticky),
        .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt)
    );

    cmp_verdict_debouncer #(.RUN_LEN(1), .CNT_W(CNT_W)) u_dut1 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .gt_in(gt_in), .lt_in(lt_in), .eq_in(eq_in),
        .verdict(verdict1), .verdict_valid(verdict_valid1),
        .verdict_chg(verdict_chg1), .fsm_state(fsm_state1),
        .err_sticky(err_sticky1),
        .gt_cnt(gt_cnt1), .lt_cnt(lt_cnt1), .eq_cnt(eq_cnt1)
    );

    typedef struct {
        logic       clr;
        logic       vld;
        logic [7:0] g, l, e;
        logic [1:0] v;
        logic       vv;
        logic       chg;
        logic [1:0] st;
        logic       er;
    } vec_t;

    vec_t vecs[28];

    function automatic vec_t mk(input logic clr, input logic vld,
                                input logic [7:0] g, input logic [7:0] l,
                                input logic [7:0] e, input logic [1:0] v,
                                input logic vv, input logic chg,
                                input logic [1:0] st, input logic er);
        vec_t r;
        r.clr = clr; r.vld = vld; r.g = g; r.l = l; r.e = e;
        r.v = v; r.vv = vv; r.chg = chg; r.st = st; r.er = er;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_main(input string tag, input logic [1:0] v,
                              input logic vv, input logic chg,
                              input logic [1:0] st, input logic er);
        check({tag, " verdict"},       32'(verdict),       32'(v));
        check({tag, " verdict_valid"}, 32'(verdict_valid), 32'(vv));
        check({tag, " verdict_chg"},   32'(verdict_chg),   32'(chg));
        check({tag, " fsm_state"},     32'(fsm_state),     32'(st));
        check({tag, " err_sticky"},    32'(err_sticky),    32'(er));
    endtask

    // Drive one cycle of inputs (called just after a rising edge), clock it
    // in, and leave time 1 unit past the next rising edge for sampling.
    task automatic step(input logic clr, input logic vld, input logic [7:0] g,
                        input logic [7:0] l, input logic [7:0] e);
        clear = clr; in_valid = vld; gt_in = g; lt_in = l; eq_in = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [CNT_W-1:0] exp_eq;

        // Main sequence for RUN_LEN=4. Columns:
        // clear, in_valid, gt, lt, eq | verdict, valid, chg, state, err
        vecs[0]  = mk(0,1,8'h01,8'h00,8'h00, 2'b00,0,0,2'b00,0); // GT 1
        vecs[1]  = mk(0,1,8'h01,8'h00,8'h00, 2'b00,0,0,2'b00,0); // GT 2
        vecs[2]  = mk(0,1,8'h01,8'h00,8'h00, 2'b00,0,0,2'b00,0); // GT 3
        vecs[3]  = mk(0,1,8'h01,8'h00,8'h00, 2'b10,1,1,2'b10,0); // GT 4 locks
        vecs[4]  = mk(0,0,8'h00,8'h00,8'h00, 2'b10,1,0,2'b10,0); // pulse ends
        vecs[5]  = mk(0,1,8'h00,8'h01,8'h00, 2'b10,1,0,2'b01,0); // LT 1
        vecs[6]  = mk(0,1,8'h00,8'h01,8'h00, 2'b10,1,0,2'b01,0); // LT 2
        vecs[7]  = mk(0,1,8'h00,8'h01,8'h00, 2'b10,1,0,2'b01,0); // LT 3
        vecs[8]  = mk(0,1,8'h01,8'h00,8'h00, 2'b10,1,0,2'b10,0); // GT aborts
        vecs[9]  = mk(0,1,8'h00,8'h00,8'h01, 2'b10,1,0,2'b01,0); // EQ 1
        vecs[10] = mk(0,0,8'h00,8'h00,8'h00, 2'b10,1,0,2'b01,0); // gap
        vecs[11] = mk(0,0,8'h00,8'h00,8'h00, 2'b10,1,0,2'b01,0);
        vecs[12] = mk(0,0,8'h00,8'h00,8'h00, 2'b10,1,0,2'b01,0);
        vecs[13] = mk(0,0,8'h00,8'h00,8'h00, 2'b10,1,0,2'b01,0);
        vecs[14] = mk(0,0,8'h00,8'h00,8'h00, 2'b10,1,0,2'b01,0);
        vecs[15] = mk(0,1,8'h00,8'h00,8'h01, 2'b10,1,0,2'b01,0); // EQ 2
        vecs[16] = mk(0,1,8'h00,8'h00,8'h01, 2'b10,1,0,2'b01,0); // EQ 3
        vecs[17] = mk(0,1,8'h00,8'h00,8'h01, 2'b11,1,1,2'b10,0); // EQ 4 locks
        vecs[18] = mk(0,1,8'h01,8'h01,8'h00, 2'b11,1,0,2'b10,1); // gt+lt illegal
        vecs[19] = mk(0,1,8'h00,8'h01,8'h00, 2'b11,1,0,2'b01,1); // LT 1
        vecs[20] = mk(0,1,8'h03,8'h00,8'h00, 2'b11,1,0,2'b10,1); // high bit illegal
        vecs[21] = mk(0,1,8'h00,8'h01,8'h00, 2'b11,1,0,2'b01,1); // LT 1 again
        vecs[22] = mk(0,1,8'h00,8'h01,8'h00, 2'b11,1,0,2'b01,1); // LT 2
        vecs[23] = mk(0,1,8'h00,8'h01,8'h00, 2'b11,1,0,2'b01,1); // LT 3
        vecs[24] = mk(0,1,8'h00,8'h01,8'h00, 2'b01,1,1,2'b10,1); // LT 4 locks
        vecs[25] = mk(1,1,8'h01,8'h00,8'h00, 2'b00,0,0,2'b00,0); // clear wins
        vecs[26] = mk(0,1,8'h00,8'h00,8'h00, 2'b00,0,0,2'b00,1); // no flag set
        vecs[27] = mk(1,0,8'h00,8'h00,8'h00, 2'b00,0,0,2'b00,0); // clear

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
        gt_in = '0; lt_in = '0; eq_in = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check_main("reset", 2'b00, 0, 0, 2'b00, 0);
        check("reset gt_cnt", 32'(gt_cnt), 32'd0);
        check("reset eq_cnt", 32'(eq_cnt), 32'd0);

        for (int i = 0; i < 28; i++) begin
            step(vecs[i].clr, vecs[i].vld, vecs[i].g, vecs[i].l, vecs[i].e);
            check_main($sformatf("vec%0d", i), vecs[i].v, vecs[i].vv,
                       vecs[i].chg, vecs[i].st, vecs[i].er);
        end

        // RUN_LEN=1 instance: every differing legal sample locks at once.
        step(0, 1, 8'h01, 8'h00, 8'h00);
        check("r1 gt verdict", 32'(verdict1),    32'(2'b10));
        check("r1 gt chg",     32'(verdict_chg1), 32'd1);
        check("r1 gt state",   32'(fsm_state1),   32'(2'b10));
        step(0, 1, 8'h00, 8'h01, 8'h00);
        check("r1 lt verdict", 32'(verdict1),    32'(2'b01));
        check("r1 lt chg",     32'(verdict_chg1), 32'd1);
        check("r1 lt state",   32'(fsm_state1),   32'(2'b10));
        step(0, 1, 8'h00, 8'h01, 8'h00);
        check("r1 same chg",   32'(verdict_chg1), 32'd0);
        check("r1 same state", 32'(fsm_state1),   32'(2'b10));

        // Asynchronous reset in the middle of a run.
        step(0, 1, 8'h01, 8'h00, 8'h00);
        step(0, 1, 8'h01, 8'h00, 8'h00);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("async rst verdict", 32'(verdict1),   32'd0);
        check("async rst state1",  32'(fsm_state1), 32'd0);
        check_main("async rst", 2'b00, 0, 0, 2'b00, 0);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        // The run must restart from zero: three GT samples do not lock.
        for (int i = 0; i < 3; i++) step(0, 1, 8'h01, 8'h00, 8'h00);
        check_main("post rst 3 GT", 2'b00, 0, 0, 2'b00, 0);
        step(0, 1, 8'h01, 8'h00, 8'h00);
        check_main("post rst 4 GT", 2'b10, 1, 1, 2'b10, 0);

        // Histogram counters: 20 legal EQ samples after a clear.
        step(1, 0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 20; i++) step(0, 1, 8'h00, 8'h00, 8'h01);
`ifdef CMP_HIST_EN
        exp_eq = 4'd15;
`else
        exp_eq = 4'd0;
`endif
        check("hist eq_cnt", 32'(eq_cnt), 32'(exp_eq));
        check("hist gt_cnt", 32'(gt_cnt), 32'd0);
        check("hist lt_cnt", 32'(lt_cnt), 32'd0);
        check_main("hist verdict", 2'b11, 1, 0, 2'b10, 0);
        // Illegal samples are not counted and clear zeroes the counters.
        step(0, 1, 8'h01, 8'h00, 8'h01);
        check("hist illegal eq_cnt", 32'(eq_cnt), 32'(exp_eq));
        check("hist illegal err",    32'(err_sticky), 32'd1);
        step(1, 0, 8'h00, 8'h00, 8'h00);
        check("hist clear eq_cnt", 32'(eq_cnt), 32'd0);
        check("hist clear err",    32'(err_sticky), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
